// File: rtl/chip_boot_pkg.sv
// Shared types and default timing constants for the chip boot sequencer.
package chip_boot_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PLL_RST    = 3'd1,
      WAIT_LOCK  = 3'd2,
      CLK_EN_DLY = 3'd3,
      RST_DLY    = 3'd4,
      INIT_DLY   = 3'd5,
      DONE       = 3'd6,
      FAIL       = 3'd7
   } boot_state_t;

   localparam int DEF_PLL_RST_CYCLES = 100;
   localparam int DEF_CLK_EN_CYCLES  = 10;
   localparam int DEF_SYS_RST_CYCLES = 100;
   localparam int DEF_INIT_CYCLES    = 50;
   localparam int DEF_LOCK_TIMEOUT   = 4096;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Width of a down-counter able to hold the largest of the five cycle counts.
   function automatic int cnt_width(input int a, input int b, input int c,
                                    input int d, input int e);
      return $clog2(max_of(max_of(max_of(a, b), max_of(c, d)), e) + 1);
   endfunction

endpackage

// File: rtl/chip_boot_if.sv
// Boot sequencer signal bundle: PLL lock / reboot request in, boot controls out.
interface chip_boot_if;
   logic       pll_lock;
   logic       soft_reboot;
   logic       pll_rst_n;
   logic       clk_en;
   logic       sys_rst_n;
   logic       jtag_rst_l;
   logic       diag_done;
   logic       ok_iob;
   logic       boot_fail;
   logic       lock_lost;
   logic [2:0] boot_state;

   modport slave (
      input  pll_lock, soft_reboot,
      output pll_rst_n, clk_en, sys_rst_n, jtag_rst_l, diag_done, ok_iob,
             boot_fail, lock_lost, boot_state
   );

   modport master (
      output pll_lock, soft_reboot,
      input  pll_rst_n, clk_en, sys_rst_n, jtag_rst_l, diag_done, ok_iob,
             boot_fail, lock_lost, boot_state
   );
endinterface

// File: rtl/chip_boot_sequencer_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   // Shift the asynchronous input through two flops; reset clears both stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep both stages a true shift register.
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/chip_boot_sequencer.sv
// Boot sequencer: PLL reset, lock wait, clock enable, reset release, init wait.
module chip_boot_sequencer
   import chip_boot_pkg::*;
#(
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int CLK_EN_CYCLES  = DEF_CLK_EN_CYCLES,
   parameter int SYS_RST_CYCLES = DEF_SYS_RST_CYCLES,
   parameter int INIT_CYCLES    = DEF_INIT_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT
) (
   input logic       clk,
   input logic       rst,
   chip_boot_if.slave bus
);
   localparam int CW = cnt_width(PLL_RST_CYCLES, CLK_EN_CYCLES, SYS_RST_CYCLES,
                                 INIT_CYCLES, LOCK_TIMEOUT);

   typedef logic [CW-1:0] cnt_t;

   // Everything that changes together on a state entry.
   typedef struct packed {
      boot_state_t state;
      cnt_t        cnt;
      logic        pll_rst_n;
      logic        clk_en;
      logic        sys_rst_n;
      logic        diag_done;
   } regs_t;

   regs_t r;
   logic  boot_fail;
   logic  lock_lost;
   logic  lock_s;
   logic  lock_range;
   logic  reboot_ok;

   // Register image for entering state s: counter preload plus the enables for s.
   function automatic regs_t enter(input boot_state_t s);
      regs_t e;
      e       = '0;
      e.state = s;
      case (s)
         PLL_RST:    e.cnt = cnt_t'(PLL_RST_CYCLES - 1);
         WAIT_LOCK:  begin
            e.cnt       = cnt_t'(LOCK_TIMEOUT - 1);
            e.pll_rst_n = 1'b1;
         end
         CLK_EN_DLY: begin
            e.cnt       = cnt_t'(CLK_EN_CYCLES - 1);
            e.pll_rst_n = 1'b1;
         end
         RST_DLY:    begin
            e.cnt       = cnt_t'(SYS_RST_CYCLES - 1);
            e.pll_rst_n = 1'b1;
            e.clk_en    = 1'b1;
         end
         INIT_DLY:   begin
            e.cnt       = cnt_t'(INIT_CYCLES - 1);
            e.pll_rst_n = 1'b1;
            e.clk_en    = 1'b1;
            e.sys_rst_n = 1'b1;
         end
         DONE:       begin
            e.pll_rst_n = 1'b1;
            e.clk_en    = 1'b1;
            e.sys_rst_n = 1'b1;
            e.diag_done = 1'b1;
         end
         default:    ;
      endcase
      return e;
   endfunction

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.pll_lock),
      .q   (lock_s)
   );

   // States in which a dropped lock forces a resequence, and in which reboot is honoured.
   assign lock_range = (r.state == CLK_EN_DLY) || (r.state == RST_DLY) ||
                       (r.state == INIT_DLY)   || (r.state == DONE);
   assign reboot_ok  = (r.state != IDLE) && (r.state != FAIL);

   // Boot FSM with shared down-counter and registered outputs; restarts take priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r         <= '0;
         boot_fail <= 1'b0;
         lock_lost <= 1'b0;
      end else if (lock_range && !lock_s) begin
         r         <= enter(PLL_RST);
         lock_lost <= 1'b1;
      end else if (bus.soft_reboot && reboot_ok) begin
         r <= enter(PLL_RST);
      end else begin
         case (r.state)
            IDLE:       r <= enter(PLL_RST);
            PLL_RST:    if (r.cnt == '0) r <= enter(WAIT_LOCK);
                        else             r.cnt <= r.cnt - 1'b1;
            WAIT_LOCK:  if (lock_s)          r <= enter(CLK_EN_DLY);
                        else if (r.cnt == '0) begin
                           r         <= enter(FAIL);
                           boot_fail <= 1'b1;
                        end else r.cnt <= r.cnt - 1'b1;
            CLK_EN_DLY: if (r.cnt == '0) r <= enter(RST_DLY);
                        else             r.cnt <= r.cnt - 1'b1;
            RST_DLY:    if (r.cnt == '0) r <= enter(INIT_DLY);
                        else             r.cnt <= r.cnt - 1'b1;
            INIT_DLY:   if (r.cnt == '0) r <= enter(DONE);
                        else             r.cnt <= r.cnt - 1'b1;
            default:    ;  // DONE and FAIL hold
         endcase
      end
   end

   assign bus.pll_rst_n  = r.pll_rst_n;
   assign bus.clk_en     = r.clk_en;
   assign bus.sys_rst_n  = r.sys_rst_n;
   assign bus.jtag_rst_l = r.sys_rst_n;
   assign bus.diag_done  = r.diag_done;
   assign bus.ok_iob     = r.diag_done;
   assign bus.boot_fail  = boot_fail;
   assign bus.lock_lost  = lock_lost;
   assign bus.boot_state = r.state;
endmodule

// File: tb/tb_chip_boot_sequencer.sv
// Directed table-driven bench for chip_boot_sequencer with default parameters.
module tb_chip_boot_sequencer;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   now;   // rising edges since the last rst release

   chip_boot_if bus ();

   chip_boot_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed vector: {pll_rst_n, clk_en, sys_rst_n, jtag_rst_l, diag_done, ok_iob,
   //                   boot_fail, lock_lost, boot_state[2:0]}
   function automatic logic [10:0] obs();
      return {bus.pll_rst_n, bus.clk_en, bus.sys_rst_n, bus.jtag_rst_l,
              bus.diag_done, bus.ok_iob, bus.boot_fail, bus.lock_lost, bus.boot_state};
   endfunction

   // Expected vector from hand values; jtag/ok_iob mirror sys_rst_n/diag_done.
   function automatic logic [10:0] v(input bit pr, input bit ce, input bit sr,
                                     input bit dd, input bit bf, input bit ll,
                                     input logic [2:0] st);
      return {pr, ce, sr, sr, dd, dd, bf, ll, st};
   endfunction

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, now);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      now++;
   endtask

   task automatic goto_edge(input int e);
      while (now < e) tick();
   endtask

   // Assert rst (asynchronously), hold 5 cycles, release just after an edge.
   task automatic do_reset(input logic lock);
      rst             = 1'b1;
      bus.soft_reboot = 1'b0;
      bus.pll_lock    = lock;
      #1;
      check("reset_async", obs(), '0);
      repeat (5) tick();
      check("reset_hold", obs(), '0);
      rst = 1'b0;
      now = 0;
   endtask

   typedef struct {
      int          edge_no;
      logic [10:0] exp;
      string       name;
   } vec_t;

   vec_t nom[11];

   initial begin
      checks          = 0;
      errors          = 0;
      now             = 0;
      rst             = 1'b1;
      bus.pll_lock    = 1'b1;
      bus.soft_reboot = 1'b0;

      nom[0]  = '{1,   v(0,0,0,0,0,0,3'd1), "nom_pll_rst_entry"};
      nom[1]  = '{100, v(0,0,0,0,0,0,3'd1), "nom_pll_rst_last"};
      nom[2]  = '{101, v(1,0,0,0,0,0,3'd2), "nom_pll_rst_n_rise"};
      nom[3]  = '{102, v(1,0,0,0,0,0,3'd3), "nom_clk_en_dly"};
      nom[4]  = '{111, v(1,0,0,0,0,0,3'd3), "nom_clk_en_pre"};
      nom[5]  = '{112, v(1,1,0,0,0,0,3'd4), "nom_clk_en_rise"};
      nom[6]  = '{211, v(1,1,0,0,0,0,3'd4), "nom_sys_rst_pre"};
      nom[7]  = '{212, v(1,1,1,0,0,0,3'd5), "nom_sys_rst_rise"};
      nom[8]  = '{261, v(1,1,1,0,0,0,3'd5), "nom_done_pre"};
      nom[9]  = '{262, v(1,1,1,1,0,0,3'd6), "nom_done_rise"};
      nom[10] = '{300, v(1,1,1,1,0,0,3'd6), "nom_done_hold"};

      // Nominal boot with lock tied high.
      do_reset(1'b1);
      for (int i = 0; i < 11; i++) begin
         goto_edge(nom[i].edge_no);
         check(nom[i].name, obs(), nom[i].exp);
      end

      // soft_reboot alone in DONE: restart, lock_lost untouched.
      bus.soft_reboot = 1'b1;
      tick();
      bus.soft_reboot = 1'b0;
      check("soft_restart", obs(), v(0,0,0,0,0,0,3'd1));
      goto_edge(400);
      check("soft_pll_rst_last", obs(), v(0,0,0,0,0,0,3'd1));
      tick();
      check("soft_wait_lock", obs(), v(1,0,0,0,0,0,3'd2));
      goto_edge(561);
      check("soft_done_pre", obs(), v(1,1,1,0,0,0,3'd5));
      tick();
      check("soft_done", obs(), v(1,1,1,1,0,0,3'd6));

      // Lock-loss and soft_reboot arriving together in RST_DLY.
      bus.soft_reboot = 1'b1;
      tick();                              // edge 563: PLL_RST re-entry
      bus.soft_reboot = 1'b0;
      goto_edge(700);
      check("simul_in_rst_dly", obs(), v(1,1,0,0,0,0,3'd4));
      bus.pll_lock = 1'b0;
      tick();
      bus.pll_lock = 1'b1;
      tick();                              // edge 702: lock_s now low
      check("simul_pre", obs(), v(1,1,0,0,0,0,3'd4));
      bus.soft_reboot = 1'b1;
      tick();
      bus.soft_reboot = 1'b0;
      check("simul_restart", obs(), v(0,0,0,0,0,1,3'd1));
      goto_edge(802);
      check("simul_single_restart_pre", obs(), v(0,0,0,0,0,1,3'd1));
      tick();
      check("simul_single_restart", obs(), v(1,0,0,0,0,1,3'd2));
      goto_edge(964);
      check("simul_done", obs(), v(1,1,1,1,0,1,3'd6));

      // Lock loss in DONE: one-cycle drop, full resequence.
      do_reset(1'b1);
      goto_edge(280);
      check("loss_in_done", obs(), v(1,1,1,1,0,0,3'd6));
      bus.pll_lock = 1'b0;
      tick();
      bus.pll_lock = 1'b1;
      tick();
      check("loss_sync_delay", obs(), v(1,1,1,1,0,0,3'd6));
      tick();
      check("loss_restart", obs(), v(0,0,0,0,0,1,3'd1));
      goto_edge(543);
      check("loss_redone_pre", obs(), v(1,1,1,0,0,1,3'd5));
      tick();
      check("loss_redone", obs(), v(1,1,1,1,0,1,3'd6));

      // Asynchronous reset mid-cycle in INIT_DLY.
      do_reset(1'b1);
      goto_edge(230);
      check("async_in_init", obs(), v(1,1,1,0,0,0,3'd5));
      #3;
      rst = 1'b1;
      #1;
      check("async_clear", obs(), '0);
      do_reset(1'b1);
      tick();
      check("async_restart", obs(), v(0,0,0,0,0,0,3'd1));
      goto_edge(102);
      check("async_reboot_clk_en_dly", obs(), v(1,0,0,0,0,0,3'd3));

      // Late lock: rises 500 cycles after PLL_RST exit.
      do_reset(1'b0);
      goto_edge(101);
      check("late_wait_lock", obs(), v(1,0,0,0,0,0,3'd2));
      goto_edge(601);
      bus.pll_lock = 1'b1;
      goto_edge(603);
      check("late_lock_pre", obs(), v(1,0,0,0,0,0,3'd2));
      tick();
      check("late_lock_t3", obs(), v(1,0,0,0,0,0,3'd3));
      goto_edge(613);
      check("late_clk_en_pre", obs(), v(1,0,0,0,0,0,3'd3));
      tick();
      check("late_clk_en_t13", obs(), v(1,1,0,0,0,0,3'd4));

      // Lock timeout into FAIL; FAIL ignores lock and soft_reboot.
      do_reset(1'b0);
      goto_edge(4196);
      check("timeout_pre", obs(), v(1,0,0,0,0,0,3'd2));
      tick();
      check("timeout_fail", obs(), v(0,0,0,0,1,0,3'd7));
      bus.pll_lock = 1'b1;
      goto_edge(4200);
      bus.soft_reboot = 1'b1;
      tick();
      bus.soft_reboot = 1'b0;
      goto_edge(4250);
      check("fail_sticky", obs(), v(0,0,0,0,1,0,3'd7));
      do_reset(1'b1);
      tick();
      check("fail_cleared_by_rst", obs(), v(0,0,0,0,0,0,3'd1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
